mult_hilo_unit: RTL

//  Sequential signed 32x32 multiplier with HI/LO registers. Responder to the ALU control unit's mult sequencing.
//  - Control holds funct=mult while counting cycles, then issues the commit code 6'b111111.
//  - This block runs the shift-add iterations, holds the 64-bit product, and writes HI/LO only on commit.
//  - Serves mfhi/mflo reads to the EX-stage result mux.

---
 rtl/mult_hilo_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/mult_hilo_unit.sv
// Sequential signed shift-add multiplier with HI/LO result registers.
// Runs one radix-2 step per cycle while funct holds mult; HI/LO change only on commit.
module mult_hilo_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [5:0] F_MULT   = 6'd24;
    localparam logic [5:0] F_MFHI   = 6'd16;
    localparam logic [5:0] F_MFLO   = 6'd18;
    localparam logic [5:0] F_COMMIT = 6'b111111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   mcand, mcand_n;
    logic [WIDTH-1:0]   mplr, mplr_n;
    logic [WIDTH-1:0]   acc, acc_n;
    logic               sign, sign_n;
    logic [WIDTH-1:0]   hi, hi_n;
    logic [WIDTH-1:0]   lo, lo_n;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_mag, product;

    // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude.
    assign mag_a    = srcA[WIDTH-1] ? (~srcA + WIDTH'(1)) : srcA;
    assign mag_b    = srcB[WIDTH-1] ? (~srcB + WIDTH'(1)) : srcB;
    assign step_sum = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : (WIDTH+1)'(0));
    assign prod_mag = {acc, mplr};
    assign product  = sign ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        dataOut = '0;
        if (funct == F_MFHI)      dataOut = hi;
        else if (funct == F_MFLO) dataOut = lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            sign  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            mcand <= mcand_n;
            mplr  <= mplr_n;
            acc   <= acc_n;
            sign  <= sign_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mcand_n = mcand;
        mplr_n  = mplr;
        acc_n   = acc;
        sign_n  = sign;
        hi_n    = hi;
        lo_n    = lo;
        case (state)
            IDLE: begin
                if (funct == F_MULT) begin
                    mcand_n = mag_a;
                    mplr_n  = mag_b;
                    sign_n  = srcA[WIDTH-1] ^ srcB[WIDTH-1];
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (funct != F_MULT) begin
                    state_n = IDLE;
                end else begin
                    // Add-then-shift: the carry out of the add becomes the new acc MSB.
                    acc_n  = step_sum[WIDTH:1];
                    mplr_n = {step_sum[0], mplr[WIDTH-1:1]};
                    cnt_n  = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) state_n = DONE;
                end
            end
            DONE: begin
                if (funct == F_COMMIT) begin
                    hi_n    = product[2*WIDTH-1:WIDTH];
                    lo_n    = product[WIDTH-1:0];
                    state_n = IDLE;
                end else if (funct != F_MULT) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
